// File: rtl/fib_seq_checker.sv
// Stream checker for the saturating additive sequence source.
// Tracks its own mx/my model and flags divergence, threshold hits and saturation.
module fib_seq_checker #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LIMIT  = 100,
  parameter int unsigned TARGET = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             hit,
  output logic             over,
  output logic             frozen,
  output logic             err,
  output logic [1:0]       state,
  output logic [7:0]       count,
  output logic [WIDTH-1:0] exp_val
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t           cur;
  state_t           nxt;
  logic [WIDTH-1:0] mx;
  logic [WIDTH-1:0] my;
  logic             accept;
  logic             match;
  logic             sat;
  logic             wipe;

  assign wipe   = !reset || clr;
  assign accept = in_valid && in_ready;
  assign match  = (in_data == mx);
  // compare at 32 bits so a LIMIT above the data range never saturates
  assign sat    = (32'(mx) >= LIMIT);

  always_ff @(posedge clk) begin
    if (wipe) cur <= IDLE;
    else      cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (accept) begin
      unique case (1'b1)
        !match:         nxt = ERROR;
        match && sat:   nxt = FROZEN;
        match && !sat:  nxt = RUN;
      endcase
    end
  end

  always_comb begin
    in_ready = (cur != ERROR) && !clr;
    frozen   = (cur == FROZEN);
    err      = (cur == ERROR);
    state    = cur;
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      mx    <= WIDTH'(1);
      my    <= WIDTH'(1);
      count <= 8'd0;
      hit   <= 1'b0;
      over  <= 1'b0;
    end else begin
      hit  <= 1'b0;
      over <= 1'b0;
      if (accept && match) begin
        if (count != 8'hff) count <= count + 8'd1;
        hit  <= (32'(in_data) == TARGET);
        over <= (32'(in_data) >  TARGET);
        my   <= mx;
        mx   <= sat ? mx : mx + my;
      end
    end
  end

  assign exp_val = mx;

endmodule

// File: tb/tb_fib_seq_checker.sv
// Scoreboard bench for fib_seq_checker: default instance plus a
// LIMIT=250/TARGET=233 instance for the threshold and wrap case.
module tb_fib_seq_checker;

  typedef struct packed {
    logic       h;
    logic       o;
    logic [1:0] st;
    logic [7:0] cnt;
    logic [7:0] ev;
  } exp_t;

  localparam logic [7:0] GD [13] = '{1,2,3,5,8,13,21,34,55,89,144,144,144};
  localparam logic [7:0] GE [13] = '{2,3,5,8,13,21,34,55,89,144,144,144,144};
  localparam logic [7:0] TD [14] = '{1,2,3,5,8,13,21,34,55,89,144,233,121,210};
  localparam logic [7:0] TE [14] = '{2,3,5,8,13,21,34,55,89,144,233,121,98,98};

  logic       clk = 0;
  logic       reset;
  logic       clr      [2];
  logic       in_valid [2];
  logic [7:0] in_data  [2];
  logic       in_ready [2];
  logic       hit      [2];
  logic       over     [2];
  logic       frozen   [2];
  logic       err      [2];
  logic [1:0] state    [2];
  logic [7:0] count    [2];
  logic [7:0] exp_val  [2];

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;

  fib_seq_checker d0 (
    .clk(clk), .reset(reset), .clr(clr[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .hit(hit[0]), .over(over[0]),
    .frozen(frozen[0]), .err(err[0]), .state(state[0]),
    .count(count[0]), .exp_val(exp_val[0])
  );

  fib_seq_checker #(.WIDTH(8), .LIMIT(250), .TARGET(233)) d1 (
    .clk(clk), .reset(reset), .clr(clr[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .hit(hit[1]), .over(over[1]),
    .frozen(frozen[1]), .err(err[1]), .state(state[1]),
    .count(count[1]), .exp_val(exp_val[1])
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic o,
                              input logic [1:0] st, input logic [7:0] cnt,
                              input logic [7:0] ev);
    exp_t e;
    e.h = h; e.o = o; e.st = st; e.cnt = cnt; e.ev = ev;
    return e;
  endfunction

  task automatic chk_out(input int k, input logic [1:0] st,
                         input logic [7:0] cnt, input logic [7:0] ev);
    chk($sformatf("d%0d_state", k), 32'(state[k]), 32'(st));
    chk($sformatf("d%0d_count", k), 32'(count[k]), 32'(cnt));
    chk($sformatf("d%0d_exp_val", k), 32'(exp_val[k]), 32'(ev));
    chk($sformatf("d%0d_err", k), 32'(err[k]), 32'(st == 2'd3));
    chk($sformatf("d%0d_frozen", k), 32'(frozen[k]), 32'(st == 2'd2));
  endtask

  task automatic pop_chk(input int k);
    exp_t e;
    int   n;
    n = (k == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL sb%0d_empty actual=accept required=no_accept", k);
      return;
    end
    if (k == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk_out(k, e.st, e.cnt, e.ev);
    chk($sformatf("d%0d_hit", k), 32'(hit[k]), 32'(e.h));
    chk($sformatf("d%0d_over", k), 32'(over[k]), 32'(e.o));
  endtask

  // monitor: every accepted sample pops one expectation
  initial begin
    bit tk [2];
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++)
        tk[k] = mon_en && reset && in_valid[k] && in_ready[k];
      #1;
      for (int k = 0; k < 2; k++) begin
        if (tk[k]) pop_chk(k);
        else if (mon_en) begin
          chk($sformatf("d%0d_idle_hit", k), 32'(hit[k]), 0);
          chk($sformatf("d%0d_idle_over", k), 32'(over[k]), 0);
        end
      end
    end
  end

  task automatic send(input int k, input logic [7:0] d, input exp_t e);
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic do_clr(input int k);
    @(negedge clk);
    in_valid[k] = 1'b0;
    clr[k]      = 1'b1;
    @(negedge clk);
    clr[k]      = 1'b0;
  endtask

  task automatic golden(input bit stall);
    for (int i = 0; i < 13; i++) begin
      if (stall) repeat ($urandom_range(0, 2)) idle(0);
      send(0, GD[i], mk(0, 0, (i < 10) ? 2'd1 : 2'd2, 8'(i + 1), GE[i]));
    end
    idle(0);
    chk_out(0, 2'd2, 8'd13, 8'd144);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clr[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = 8'd0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk_out(k, 2'd0, 8'd0, 8'd1);
      chk($sformatf("d%0d_rst_hit", k), 32'(hit[k]), 0);
      chk($sformatf("d%0d_rst_ready", k), 32'(in_ready[k]), 1);
    end
    reset  = 1'b1;
    mon_en = 1'b1;

    golden(1'b0);

    do_clr(0);
    send(0, 8'd1, mk(0, 0, 2'd1, 8'd1, 8'd2));
    send(0, 8'd2, mk(0, 0, 2'd1, 8'd2, 8'd3));
    send(0, 8'd3, mk(0, 0, 2'd1, 8'd3, 8'd5));
    send(0, 8'd6, mk(0, 0, 2'd3, 8'd3, 8'd5));
    @(negedge clk);
    in_data[0] = 8'd5;
    chk("d0_err_ready", 32'(in_ready[0]), 0);
    repeat (2) @(negedge clk);
    chk_out(0, 2'd3, 8'd3, 8'd5);

    @(negedge clk);
    clr[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 8'd1;
    chk("d0_clr_ready", 32'(in_ready[0]), 0);
    @(negedge clk);
    clr[0] = 1'b0; in_valid[0] = 1'b0;
    chk_out(0, 2'd0, 8'd0, 8'd1);
    send(0, 8'd1, mk(0, 0, 2'd1, 8'd1, 8'd2));

    do_clr(0);
    golden(1'b1);

    do_clr(0);
    for (int i = 0; i < 6; i++)
      send(0, GD[i], mk(0, 0, 2'd1, 8'(i + 1), GE[i]));
    @(negedge clk);
    in_valid[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_out(0, 2'd0, 8'd0, 8'd1);
    reset = 1'b1;
    send(0, 8'd1, mk(0, 0, 2'd1, 8'd1, 8'd2));
    send(0, 8'd2, mk(0, 0, 2'd1, 8'd2, 8'd3));
    idle(0);

    for (int i = 0; i < 14; i++)
      send(1, TD[i], mk(i == 11, 0, (i < 13) ? 2'd1 : 2'd3,
                        (i < 13) ? 8'(i + 1) : 8'd13, TE[i]));
    idle(1);
    repeat (3) @(negedge clk);
    chk_out(1, 2'd3, 8'd13, 8'd98);
    chk("sb0_left", q0.size(), 0);
    chk("sb1_left", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
